// File: rtl/rdout_train_ctrl.sv
// rdout_train_ctrl
// Sequencer for the readout trainer's online-learning datapath.
// Issues one training-sample address per cycle for a programmed number of
// epochs, then holds the readout clock-enable high for LATENCY more cycles so
// the final weight update reaches the readout before the outputs are frozen.
// A matching valid/index delay line tags each estimate with its sample index.
//
// Optional build macro: RDOUT_CTRL_EPOCH_TICK_EN
//   When defined, adds output epoch_tick, a one-cycle pulse aligned with
//   est_valid whenever est_idx is the last sample of an epoch.
//
// Handshake note: start and abort are single-cycle request pulses sampled on
// the rising clock edge. start is accepted only in IDLE/DONE with a non-zero
// n_epochs and no abort in the same cycle; abort is always accepted and wins
// over start. est_valid is a pure qualifier (no back-pressure): est_idx is
// meaningful only in cycles where est_valid is high.
//
// LATENCY must be at least 1.

module rdout_train_ctrl #(
    parameter int ADDR_W    = 6,
    parameter int N_SAMPLES = 64,
    parameter int LATENCY   = 4,
    parameter int EPOCH_W   = 8
) (
    input  logic               clk,
    input  logic               rst_N,
    input  logic               start,
    input  logic               abort,
    input  logic [EPOCH_W-1:0] n_epochs,
    output logic [ADDR_W-1:0]  addr,
    output logic               rd_ce,
    output logic               est_valid,
    output logic [ADDR_W-1:0]  est_idx,
    output logic [EPOCH_W-1:0] epoch,
    output logic               busy,
    output logic               done,
`ifdef RDOUT_CTRL_EPOCH_TICK_EN
    output logic               epoch_tick,
`endif
    output logic [1:0]         dbg_state_o
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_TRAIN = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    localparam logic [ADDR_W-1:0]  LAST_ADDR  = ADDR_W'(N_SAMPLES - 1);
    localparam logic [EPOCH_W-1:0] EPOCH_MAX  = {EPOCH_W{1'b1}};
    localparam logic [CNT_W-1:0]   DRAIN_LOAD = CNT_W'(LATENCY - 1);

    logic [1:0]         state_q, state_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [EPOCH_W-1:0] epoch_q, epoch_d;
    logic [EPOCH_W-1:0] limit_q, limit_d;
    logic [CNT_W-1:0]   drain_q, drain_d;

    // Delay lines: stage 0 captures the current cycle, stage LATENCY-1 is
    // what the readout output corresponds to.
    logic [LATENCY-1:0] vld_q;
    logic [ADDR_W-1:0]  idx_q [LATENCY];

    logic               issue;
    logic               start_ok;
    logic               at_last;
    logic [EPOCH_W-1:0] epoch_inc;

    assign issue    = (state_q == S_TRAIN);
    assign at_last  = (addr_q == LAST_ADDR);
    assign start_ok = start && !abort && (n_epochs != '0) &&
                      ((state_q == S_IDLE) || (state_q == S_DONE));

    // Epoch increment saturates so an oversize count can never wrap to zero.
    assign epoch_inc = (epoch_q == EPOCH_MAX) ? epoch_q : (epoch_q + 1'b1);

    // Next-state logic for the sequencer: abort overrides everything.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        epoch_d = epoch_q;
        limit_d = limit_q;
        drain_d = drain_q;
        if (abort) begin
            state_d = S_IDLE;
            addr_d  = '0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start_ok) begin
                        state_d = S_TRAIN;
                        addr_d  = '0;
                        epoch_d = '0;
                        limit_d = n_epochs;
                    end
                end
                S_TRAIN: begin
                    if (at_last) begin
                        addr_d  = '0;
                        epoch_d = epoch_inc;
                        if (epoch_inc == limit_q) begin
                            state_d = S_DRAIN;
                            drain_d = DRAIN_LOAD;
                        end
                    end else begin
                        addr_d = addr_q + 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (drain_q == '0) begin
                        state_d = S_DONE;
                    end else begin
                        drain_d = drain_q - 1'b1;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    addr_d  = '0;
                end
            endcase
        end
    end

    // Sequencer state registers.
    always_ff @(posedge clk or negedge rst_N) begin
        if (!rst_N) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            epoch_q <= '0;
            limit_q <= '0;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            epoch_q <= epoch_d;
            limit_q <= limit_d;
            drain_q <= drain_d;
        end
    end

    // Valid/index delay line; abort flushes in-flight samples.
    always_ff @(posedge clk or negedge rst_N) begin
        if (!rst_N) begin
            vld_q <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                idx_q[i] <= '0;
            end
        end else if (abort) begin
            vld_q <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                idx_q[i] <= '0;
            end
        end else begin
            vld_q[0] <= issue;
            idx_q[0] <= addr_q;
            for (int i = 1; i < LATENCY; i++) begin
                vld_q[i] <= vld_q[i-1];
                idx_q[i] <= idx_q[i-1];
            end
        end
    end

    assign addr        = addr_q;
    assign epoch       = epoch_q;
    assign busy        = (state_q == S_TRAIN) || (state_q == S_DRAIN);
    assign rd_ce       = busy;
    assign done        = (state_q == S_DONE);
    assign est_valid   = vld_q[LATENCY-1];
    assign est_idx     = idx_q[LATENCY-1];
    assign dbg_state_o = state_q;

`ifdef RDOUT_CTRL_EPOCH_TICK_EN
    // Marks the last sample of each epoch as it lands at the readout.
    assign epoch_tick = est_valid && (est_idx == LAST_ADDR);
`endif

`ifndef SYNTHESIS
    a_est_needs_ce : assert property (@(posedge clk) disable iff (!rst_N)
        est_valid |-> rd_ce);
    a_done_not_busy : assert property (@(posedge clk) disable iff (!rst_N)
        done |-> !busy);
`endif

endmodule

// File: tb/tb_rdout_train_ctrl.sv
// Bench for rdout_train_ctrl: directed scenarios plus randomized runs.
// Expected estimate indices are queued when a run is launched and are
// popped by an independent monitor whenever est_valid is seen.
`timescale 1ns/1ps

module tb_rdout_train_ctrl;

    localparam int ADDR_W  = 6;
    localparam int N       = 64;
    localparam int L       = 4;
    localparam int EPOCH_W = 8;

    logic               clk;
    logic               rst_N;
    logic               start;
    logic               abort;
    logic [EPOCH_W-1:0] n_epochs;
    logic [ADDR_W-1:0]  addr;
    logic               rd_ce;
    logic               est_valid;
    logic [ADDR_W-1:0]  est_idx;
    logic [EPOCH_W-1:0] epoch;
    logic               busy;
    logic               done;
`ifdef RDOUT_CTRL_EPOCH_TICK_EN
    logic               epoch_tick;
    int                 tick_cnt;
`endif
    logic [1:0]         dbg_state;

    int n_checks;
    int n_fail;
    logic [ADDR_W-1:0] exp_q[$];

    rdout_train_ctrl #(
        .ADDR_W   (ADDR_W),
        .N_SAMPLES(N),
        .LATENCY  (L),
        .EPOCH_W  (EPOCH_W)
    ) dut (
        .clk        (clk),
        .rst_N      (rst_N),
        .start      (start),
        .abort      (abort),
        .n_epochs   (n_epochs),
        .addr       (addr),
        .rd_ce      (rd_ce),
        .est_valid  (est_valid),
        .est_idx    (est_idx),
        .epoch      (epoch),
        .busy       (busy),
        .done       (done),
`ifdef RDOUT_CTRL_EPOCH_TICK_EN
        .epoch_tick (epoch_tick),
`endif
        .dbg_state_o(dbg_state)
    );

    // Clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag, input logic [31:0] exp_done,
                                      input logic [31:0] exp_epoch);
        check({tag, "_addr"},  32'(addr), 0);
        check({tag, "_rd_ce"}, 32'(rd_ce), 0);
        check({tag, "_busy"},  32'(busy), 0);
        check({tag, "_done"},  32'(done), exp_done);
        check({tag, "_est_valid"}, 32'(est_valid), 0);
        check({tag, "_epoch"}, 32'(epoch), exp_epoch);
    endtask

    // Monitor: every presented estimate must match the head of the queue.
    always @(negedge clk) begin
        if (rst_N) begin
            if (est_valid) begin
                logic [ADDR_W-1:0] want;
                check("est_expected", 32'(exp_q.size() > 0), 1);
                want = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
                check("est_idx", 32'(est_idx), 32'(want));
                check("est_rd_ce", 32'(rd_ce), 1);
`ifdef RDOUT_CTRL_EPOCH_TICK_EN
                check("epoch_tick", 32'(epoch_tick), 32'(int'(want) == N - 1));
                if (epoch_tick) tick_cnt++;
`endif
            end
`ifdef RDOUT_CTRL_EPOCH_TICK_EN
            else begin
                check("epoch_tick_idle", 32'(epoch_tick), 0);
            end
`endif
        end
    end

    // One training run. abort_k / start_k / rst_k give the cycle index
    // (0 = first TRAIN cycle) for an injected event, or -1 for none.
    task automatic do_run(input int n, input int abort_k, input int start_k, input int rst_k);
        int total;
        int cnt;
        int cut;
        int e_addr;
        int e_epoch;
        total = n * N + L;
        cnt   = n * N;
        cut   = (abort_k >= 0) ? abort_k : rst_k;
        // An estimate issued at cycle i appears at cycle i+L.
        if (cut >= 0) begin
            cnt = cut - L + 1;
            if (cnt < 0) cnt = 0;
            if (cnt > n * N) cnt = n * N;
        end
        for (int i = 0; i < cnt; i++) exp_q.push_back(ADDR_W'(i % N));

        @(negedge clk);
        start    = 1'b1;
        n_epochs = EPOCH_W'(n);
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < total; k++) begin
            e_addr  = (k < n * N) ? (k % N) : 0;
            e_epoch = (k < n * N) ? (k / N) : n;
            check("run_addr",  32'(addr),  32'(e_addr));
            check("run_epoch", 32'(epoch), 32'(e_epoch));
            check("run_busy",  32'(busy),  1);
            check("run_rd_ce", 32'(rd_ce), 1);
            check("run_done",  32'(done),  0);
            if (k == start_k) begin
                start    = 1'b1;
                n_epochs = 8'd7;
            end
            if (k == abort_k) begin
                abort = 1'b1;
                @(negedge clk);
                abort = 1'b0;
                start = 1'b0;
                check_idle_outputs("abort", 0, 32'(e_epoch));
                #1;
                check("abort_q_empty", 32'(exp_q.size()), 0);
                return;
            end
            if (k == rst_k) begin
                #1;
                rst_N = 1'b0;
                #1;
                check_idle_outputs("async_rst", 0, 0);
                check("async_rst_est_idx", 32'(est_idx), 0);
                check("rst_q_empty", 32'(exp_q.size()), 0);
                @(negedge clk);
                rst_N = 1'b1;
                return;
            end
            @(negedge clk);
            start = 1'b0;
        end
        check_idle_outputs("end", 1, 32'(n));
        @(negedge clk);
        #1;
        check("end_q_empty", 32'(exp_q.size()), 0);
        check("end_done_hold", 32'(done), 1);
    endtask

    initial begin
        int rn;
        int rk;
        n_checks = 0;
        n_fail   = 0;
`ifdef RDOUT_CTRL_EPOCH_TICK_EN
        tick_cnt = 0;
`endif
        rst_N    = 1'b0;
        start    = 1'b0;
        abort    = 1'b0;
        n_epochs = '0;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset", 0, 0);
        check("reset_est_idx", 32'(est_idx), 0);
        rst_N = 1'b1;
        @(negedge clk);

        // Single epoch, then three epochs back to back from DONE.
        do_run(1, -1, -1, -1);
        do_run(3, -1, -1, -1);

        // Start during TRAIN is ignored.
        do_run(1, -1, 10, -1);

        // Abort from DONE, then a zero-epoch start stays idle.
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check_idle_outputs("abort_done", 0, 1);
        start    = 1'b1;
        n_epochs = '0;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("zero_start_busy", 32'(busy), 0);
            check("zero_start_done", 32'(done), 0);
            @(negedge clk);
        end

        // Abort mid-epoch, then abort+start together in IDLE.
        do_run(2, 20, -1, -1);
        start    = 1'b1;
        abort    = 1'b1;
        n_epochs = 8'd2;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        check_idle_outputs("abort_wins_idle", 0, 0);

        // Abort+start together from DONE.
        do_run(1, -1, -1, -1);
        start    = 1'b1;
        abort    = 1'b1;
        n_epochs = 8'd1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        check_idle_outputs("abort_wins_done", 0, 1);

        // Reset during DRAIN, then a normal run.
        do_run(1, -1, -1, N + 2);
        do_run(1, -1, -1, -1);

`ifdef RDOUT_CTRL_EPOCH_TICK_EN
        tick_cnt = 0;
        do_run(2, -1, -1, -1);
        check("epoch_tick_count", 32'(tick_cnt), 2);
`endif

        // Randomized runs, some with an abort at a random cycle.
        for (int r = 0; r < 6; r++) begin
            rn = int'($urandom_range(1, 3));
            rk = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, rn * N + L - 1)) : -1;
            do_run(rn, rk, -1, -1);
        end

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
